p2s: RTL and testbench



---
 rtl/msdap_pkg.sv | 22 ++
 rtl/p2s.sv | 88 ++++++++
 tb/tb_p2s.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/msdap_pkg.sv
//------------------------------------------------------------------------------
// Module   : msdap_pkg
// Purpose  : Shared definitions for the MSDAP output path.
//            P2S_DATA_W  - width of the parallel word serialised by p2s
//            p2s_state_t - p2s control states (IDLE, SHIFT)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package msdap_pkg;

  localparam int P2S_DATA_W = 40;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

endpackage : msdap_pkg

`default_nettype wire

// File: rtl/p2s.sv
//------------------------------------------------------------------------------
// Module   : p2s
// Purpose  : Parallel-to-serial transmitter. Captures a DATA_W-bit word on a
//            one-cycle LOAD strobe and shifts it out MSB-first on DATAOUT, one
//            bit per SCLK cycle, with OutReady marking valid bit cycles.
// Ports    : SCLK     in   system clock, rising edge
//            CLR      in   synchronous active-high reset (priority over LOAD)
//            LOAD     in   start strobe; reloads and restarts when asserted
//            PDATAIN  in   parallel word, sampled only when LOAD=1
//            DATAOUT  out  serial data, MSB first, registered
//            OutReady out  high while DATAOUT carries a valid bit, registered
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module p2s
  import msdap_pkg::*;
#(
  parameter int DATA_W = P2S_DATA_W
) (
  input  logic              SCLK,
  input  logic              CLR,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] PDATAIN,
  output logic              DATAOUT,
  output logic              OutReady
);

  localparam int              CNT_W  = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  p2s_state_t        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;
  logic              r_dataout;
  logic              r_outready;

  assign DATAOUT  = r_dataout;
  assign OutReady = r_outready;

  // The MSB goes straight to DATAOUT at the load edge, so the shift register
  // only holds the remaining DATA_W-1 bits and the counter counts how many
  // are still to come. count==0 in SHIFT means the last bit is on the wire.
  always_ff @(posedge SCLK) begin
    if (CLR) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_count    <= '0;
      r_dataout  <= 1'b0;
      r_outready <= 1'b0;
    end else if (LOAD) begin
      // Same action from IDLE or mid-word: the old word is abandoned.
      r_state    <= SHIFT;
      r_dataout  <= PDATAIN[DATA_W-1];
      r_shreg    <= PDATAIN << 1;
      r_count    <= C_LAST;
      r_outready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_dataout  <= 1'b0;
          r_outready <= 1'b0;
        end
        SHIFT: begin
          if (r_count != '0) begin
            r_dataout  <= r_shreg[DATA_W-1];
            r_shreg    <= r_shreg << 1;
            r_count    <= r_count - 1'b1;
            r_outready <= 1'b1;
          end else begin
            r_state    <= IDLE;
            r_dataout  <= 1'b0;
            r_outready <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_dataout  <= 1'b0;
          r_outready <= 1'b0;
        end
      endcase
    end
  end

endmodule : p2s

`default_nettype wire

// File: tb/tb_p2s.sv
//------------------------------------------------------------------------------
// Module   : tb_p2s
// Purpose  : Self-checking bench for p2s. A word/bit-index reference model
//            predicts DATAOUT and OutReady every cycle; directed scenarios
//            also reassemble transmitted words and compare whole values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_p2s;
  import msdap_pkg::*;

  localparam int W = P2S_DATA_W;

  logic         SCLK = 1'b0;
  logic         CLR  = 1'b1;
  logic         LOAD = 1'b0;
  logic [W-1:0] PDATAIN = '0;
  logic         DATAOUT;
  logic         OutReady;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the word in flight and how many cycles since its load.
  logic [W-1:0] m_word = '0;
  int           m_k    = 0;
  bit           m_act  = 1'b0;

  // Observed: reassembled bits and the current run of OutReady=1 cycles.
  logic [W-1:0] cap = '0;
  int           run = 0;

  p2s u_dut (
    .SCLK     (SCLK),
    .CLR      (CLR),
    .LOAD     (LOAD),
    .PDATAIN  (PDATAIN),
    .DATAOUT  (DATAOUT),
    .OutReady (OutReady)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Drive one cycle of inputs, advance the model at the rising edge, then
  // compare outputs at the following falling edge.
  task automatic step(input logic clr, input logic load, input logic [W-1:0] d);
    logic exp_dout;
    CLR     = clr;
    LOAD    = load;
    PDATAIN = d;
    @(posedge SCLK);
    if (clr) begin
      m_act = 1'b0;
    end else if (load) begin
      m_word = d;
      m_k    = 0;
      m_act  = 1'b1;
    end else if (m_act) begin
      m_k++;
      if (m_k == W) m_act = 1'b0;
    end
    exp_dout = m_act ? m_word[W-1-m_k] : 1'b0;
    @(negedge SCLK);
    chk("ready", {63'd0, OutReady}, {63'd0, m_act});
    chk("dout",  {63'd0, DATAOUT},  {63'd0, exp_dout});
    if (OutReady) begin
      cap = {cap[W-2:0], DATAOUT};
      run++;
    end else begin
      run = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_word());
  endtask

  // Load a word and run its remaining W-1 bit cycles.
  task automatic send(input logic [W-1:0] d);
    step(1'b0, 1'b1, d);
    idle(W - 1);
  endtask

  initial begin
    logic [W-1:0] w;
    @(negedge SCLK);

    // Reset dominates LOAD.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd_word());
    chk("rst_ready", {63'd0, OutReady}, 64'd0);

    // Basic word, then one idle cycle where OutReady must fall.
    send(40'hA5A5A5A5A5);
    chk("basic_word", {24'd0, cap}, {24'd0, 40'hA5A5A5A5A5});
    chk("basic_run", run, W);
    idle(1);
    chk("basic_end", {63'd0, OutReady}, 64'd0);

    // Edge patterns.
    send(40'h8000000001);
    chk("edge_word", {24'd0, cap}, {24'd0, 40'h8000000001});
    idle(2);
    send(40'h0);
    chk("zero_word", {24'd0, cap}, 64'd0);
    chk("zero_run", run, W);
    idle(2);

    // Back-to-back: second LOAD on the edge where OutReady would fall.
    send(40'hA5A5A5A5A5);
    send(40'hFFFFFFFFFF);
    chk("b2b_run", run, 2 * W);
    chk("b2b_word", {24'd0, cap}, {24'd0, 40'hFFFFFFFFFF});
    idle(2);

    // Abort at cycle 10 of a transfer.
    step(1'b0, 1'b1, 40'hA5A5A5A5A5);
    idle(9);
    send(40'h0F0F0F0F0F);
    chk("abort_word", {24'd0, cap}, {24'd0, 40'h0F0F0F0F0F});
    chk("abort_run", run, W + 10);
    idle(1);

    // CLR mid-word at cycle 20, then a full new word.
    step(1'b0, 1'b1, 40'hA5A5A5A5A5);
    idle(19);
    step(1'b1, 1'b0, rnd_word());
    chk("clr_ready", {63'd0, OutReady}, 64'd0);
    idle(3);
    w = rnd_word();
    send(w);
    chk("post_clr_word", {24'd0, cap}, {24'd0, w});
    idle(1);

    // Randomised traffic: sparse LOADs, occasional CLR, held LOADs.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 299);
      step(r == 0, (r > 0) && (r < 10), rnd_word());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_p2s

`default_nettype wire
